// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller.
// Start table, halt default and FSM state encoding.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int START_TBL [4] = '{0, 32, 64, 96};
  localparam int HALT_PC_DEF = 128;

endpackage

// File: rtl/run_ctrl_mem_arb.sv
// Data-memory port mux between core and host.
// Ownership follows the run controller state.
module mem_arb
  import run_ctrl_pkg::*;
(
  input  logic       rst,
  input  logic [1:0] state,
  input  logic       core_we,
  input  logic [7:0] core_addr,
  input  logic [7:0] core_din,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_din,
  output logic       host_gnt,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din
);

  logic core_own;
  logic host_own;

  assign core_own = !rst && (state == RUN);
  assign host_own = !rst &&
    ((state == IDLE) || (state == DONE));

  always_comb begin
    host_gnt = 1'b0;
    mem_we   = 1'b0;
    mem_addr = 8'h00;
    mem_din  = 8'h00;
    unique case (1'b1)
      core_own: begin
        mem_we   = core_we;
        mem_addr = core_addr;
        mem_din  = core_din;
      end
      host_own: begin
        host_gnt = host_req;
        mem_we   = host_req & host_we;
        mem_addr = host_addr;
        mem_din  = host_din;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: start/halt/timeout sequencing of one core run
// and arbitration of the data-memory port with the host.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          D       = 12,
  parameter int          HALT_PC = HALT_PC_DEF,
  parameter logic [15:0] MAX_CYC = 16'hFFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   prog_sel,
  input  logic [D-1:0] pc,
  input  logic         core_we,
  input  logic [7:0]   core_addr,
  input  logic [7:0]   core_din,
  input  logic         host_req,
  input  logic         host_we,
  input  logic [7:0]   host_addr,
  input  logic [7:0]   host_din,
  output logic         host_gnt,
  output logic         mem_we,
  output logic [7:0]   mem_addr,
  output logic [7:0]   mem_din,
  output logic         pc_load,
  output logic [D-1:0] pc_load_val,
  output logic         core_en,
  output logic         done,
  output logic         timeout,
  output logic [15:0]  cyc_cnt
);

  state_t state;
  state_t state_nx;
  logic   start_q;
  logic   armed;
  logic   start_edge;
  logic   halt;
  logic   limit;

  // armed stays low until start is seen low, so a level
  // held across reset release cannot launch a run
  assign start_edge = start & ~start_q & armed;
  assign halt       = (pc == D'(HALT_PC));
  assign limit      = (cyc_cnt == MAX_CYC);
  assign core_en    = (state == RUN);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start_edge) state_nx = LOAD;
      LOAD:       state_nx = RUN;
      RUN:        if (halt || limit) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      armed       <= 1'b0;
      pc_load     <= 1'b0;
      pc_load_val <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cyc_cnt     <= 16'h0000;
    end else begin
      state   <= state_nx;
      start_q <= start;
      if (!start) armed <= 1'b1;
      pc_load <= (state_nx == LOAD);
      if (state_nx == LOAD) begin
        pc_load_val <= D'(START_TBL[prog_sel]);
        done        <= 1'b0;
        timeout     <= 1'b0;
        cyc_cnt     <= 16'h0000;
      end
      if (state == RUN) begin
        if (state_nx == DONE) begin
          done    <= 1'b1;
          timeout <= ~halt;
        end else if (cyc_cnt != 16'hFFFF) begin
          cyc_cnt <= cyc_cnt + 16'd1;
        end
      end
    end
  end

  mem_arb u_arb (
    .rst       (reset),
    .state     (state),
    .core_we   (core_we),
    .core_addr (core_addr),
    .core_din  (core_din),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_din  (host_din),
    .host_gnt  (host_gnt),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized bench for run_ctrl against a run-level model:
// each run ends after min(k, MAX) RUN cycles, timeout iff k > MAX.
module tb_run_ctrl;

  localparam int D    = 12;
  localparam int HALT = 128;
  localparam int MAXC = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   prog_sel;
  logic [D-1:0] pc;
  logic         core_we;
  logic [7:0]   core_addr;
  logic [7:0]   core_din;
  logic         host_req;
  logic         host_we;
  logic [7:0]   host_addr;
  logic [7:0]   host_din;
  logic         host_gnt;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_din;
  logic         pc_load;
  logic [D-1:0] pc_load_val;
  logic         core_en;
  logic         done;
  logic         timeout;
  logic [15:0]  cyc_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int tbl [4] = '{0, 32, 64, 96};

  run_ctrl #(
    .D       (D),
    .HALT_PC (HALT),
    .MAX_CYC (16'(MAXC))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .prog_sel    (prog_sel),
    .pc          (pc),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_din    (core_din),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_din    (host_din),
    .host_gnt    (host_gnt),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .core_en     (core_en),
    .done        (done),
    .timeout     (timeout),
    .cyc_cnt     (cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D-1:0] rand_pc();
    logic [D-1:0] v;
    v = D'($urandom);
    if (v == D'(HALT)) v = v + 1'b1;
    return v;
  endfunction

  task automatic rnd_bus;
    core_we   = 1'($urandom);
    core_addr = 8'($urandom);
    core_din  = 8'($urandom);
    host_req  = 1'($urandom);
    host_we   = 1'($urandom);
    host_addr = 8'($urandom);
    host_din  = 8'($urandom);
  endtask

  task automatic chk_host(input string tag);
    chk({tag, "_gnt"}, 32'(host_gnt), 32'(host_req));
    chk({tag, "_we"}, 32'(mem_we),
        32'(host_req & host_we));
    chk({tag, "_addr"}, 32'(mem_addr), 32'(host_addr));
    chk({tag, "_din"}, 32'(mem_din), 32'(host_din));
  endtask

  task automatic chk_run(input int i);
    chk("run_en", 32'(core_en), 32'd1);
    chk("run_cyc", 32'(cyc_cnt), 32'(i));
    chk("run_done", 32'(done), 32'd0);
    chk("run_we", 32'(mem_we), 32'(core_we));
    chk("run_addr", 32'(mem_addr), 32'(core_addr));
    chk("run_din", 32'(mem_din), 32'(core_din));
    chk("run_gnt", 32'(host_gnt), 32'd0);
  endtask

  // k = RUN cycles before pc reaches HALT
  task automatic do_run(input int sel, input int k,
                        input bit hold);
    int last;
    int exp_cyc;
    bit exp_to;
    last    = (k <= MAXC) ? k : MAXC;
    exp_cyc = last;
    exp_to  = (k > MAXC);
    prog_sel = 2'(sel);
    start    = 1'b1;
    pc       = rand_pc();
    rnd_bus();
    tick();
    rnd_bus();
    #1;
    chk("ld_pulse", 32'(pc_load), 32'd1);
    chk("ld_val", 32'(pc_load_val), 32'(tbl[sel]));
    chk("ld_en", 32'(core_en), 32'd0);
    chk("ld_done", 32'(done), 32'd0);
    chk("ld_to", 32'(timeout), 32'd0);
    chk("ld_cyc", 32'(cyc_cnt), 32'd0);
    chk("ld_we", 32'(mem_we), 32'd0);
    chk("ld_gnt", 32'(host_gnt), 32'd0);
    prog_sel = 2'($urandom);
    if (!hold) start = 1'b0;
    tick();
    chk("ld_end", 32'(pc_load), 32'd0);
    for (int i = 0; i <= last; i++) begin
      pc = (i == k) ? D'(HALT) : rand_pc();
      rnd_bus();
      if (!hold) start = 1'($urandom);
      #1;
      chk_run(i);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      rnd_bus();
      pc = 1'($urandom) ? D'(HALT) : rand_pc();
      #1;
      chk("dn_done", 32'(done), 32'd1);
      chk("dn_to", 32'(timeout), 32'(exp_to));
      chk("dn_cyc", 32'(cyc_cnt), 32'(exp_cyc));
      chk("dn_en", 32'(core_en), 32'd0);
      chk("dn_ld", 32'(pc_load), 32'd0);
      chk_host("dn");
      tick();
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    prog_sel = 2'd0;
    pc       = '0;
    core_we  = 1'b0;
    core_addr = 8'h00;
    core_din = 8'h00;
    host_req = 1'b1;
    host_we  = 1'b1;
    host_addr = 8'h33;
    host_din = 8'h44;
    tick();
    tick();
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    chk("rst_cyc", 32'(cyc_cnt), 32'd0);
    chk("rst_ld", 32'(pc_load), 32'd0);
    chk("rst_en", 32'(core_en), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_gnt", 32'(host_gnt), 32'd0);
    reset = 1'b0;
    tick();
    chk_host("idle");
    tick();

    do_run(2, 40, 1'b0);
    do_run(1, MAXC + 30, 1'b0);
    do_run(3, MAXC, 1'b0);
    do_run(0, 0, 1'b0);
    do_run(2, 7, 1'b1);
    do_run(1, 3, 1'b0);

    // abort a run with a reset pulse while the core is writing
    prog_sel = 2'd1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      pc = rand_pc();
      tick();
    end
    core_we  = 1'b1;
    host_req = 1'b1;
    host_we  = 1'b1;
    start    = 1'b1;
    #1;
    chk("pre_rst_en", 32'(core_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("ab_we", 32'(mem_we), 32'd0);
    chk("ab_en", 32'(core_en), 32'd0);
    chk("ab_cyc", 32'(cyc_cnt), 32'd0);
    chk("ab_gnt", 32'(host_gnt), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held_ld", 32'(pc_load), 32'd0);
      chk("held_en", 32'(core_en), 32'd0);
    end
    start = 1'b0;
    tick();
    do_run(0, 12, 1'b0);

    for (int r = 0; r < 12; r++) begin
      do_run(int'($urandom_range(0, 3)),
             int'($urandom_range(0, MAXC + 15)),
             1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
